// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiplier and restoring divider, one bit per RUN cycle.
// The divider is built only when MULDIV_DIV_EN is defined; otherwise divide ops finish at once with zero results.
module muldiv_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_by_zero
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic [63:0] acc;
   logic [31:0] operand;
   logic        neg_lo;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [32:0] mul_sum;
   logic [63:0] step_next;
   logic [63:0] prod_signed;
   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic        res_dbz;
`ifdef MULDIV_DIV_EN
   logic        is_div;
   logic        neg_hi;
   logic        div_zero;
   logic [31:0] dividend;
   logic [33:0] div_diff;
`endif

   // Signed ops iterate on magnitudes; the sign is reapplied when entering DONE.
   assign a_mag = (~op[0] & in1[31]) ? (32'd0 - in1) : in1;
   assign b_mag = (~op[0] & in2[31]) ? (32'd0 - in2) : in2;

   always_comb begin
      mul_sum   = {1'b0, acc[63:32]} + {1'b0, operand};
      step_next = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:32], acc[31:1]};
`ifdef MULDIV_DIV_EN
      // acc holds {remainder, dividend/quotient}; the trial subtract uses the shifted remainder.
      div_diff = {1'b0, acc[63:31]} - {2'b00, operand};
      if (is_div) begin
         if (div_diff[33])
            step_next = {acc[62:0], 1'b0};
         else
            step_next = {div_diff[31:0], acc[30:0], 1'b1};
      end
`endif
   end

   always_comb begin
      prod_signed = neg_lo ? (64'd0 - step_next) : step_next;
      res_hi      = prod_signed[63:32];
      res_lo      = prod_signed[31:0];
      res_dbz     = 1'b0;
`ifdef MULDIV_DIV_EN
      if (is_div) begin
         res_lo = neg_lo ? (32'd0 - step_next[31:0]) : step_next[31:0];
         res_hi = neg_hi ? (32'd0 - step_next[63:32]) : step_next[63:32];
         if (div_zero) begin
            res_lo  = 32'hFFFF_FFFF;
            res_hi  = dividend;
            res_dbz = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= 5'd0;
         acc         <= 64'd0;
         operand     <= 32'd0;
         neg_lo      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         hi          <= 32'd0;
         lo          <= 32'd0;
         div_by_zero <= 1'b0;
`ifdef MULDIV_DIV_EN
         is_div      <= 1'b0;
         neg_hi      <= 1'b0;
         div_zero    <= 1'b0;
         dividend    <= 32'd0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  cnt    <= 5'd0;
                  busy   <= 1'b1;
                  neg_lo <= ~op[0] & (in1[31] ^ in2[31]);
`ifdef MULDIV_DIV_EN
                  is_div   <= op[1];
                  neg_hi   <= ~op[0] & in1[31];
                  div_zero <= op[1] & (in2 == 32'd0);
                  dividend <= in1;
                  acc      <= {32'd0, op[1] ? a_mag : b_mag};
                  operand  <= op[1] ? b_mag : a_mag;
                  state    <= RUN;
`else
                  if (op[1]) begin
                     state       <= DONE;
                     done        <= 1'b1;
                     hi          <= 32'd0;
                     lo          <= 32'd0;
                     div_by_zero <= 1'b0;
                  end else begin
                     acc     <= {32'd0, b_mag};
                     operand <= a_mag;
                     state   <= RUN;
                  end
`endif
               end
            end
            RUN: begin
               acc <= step_next;
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  state       <= DONE;
                  done        <= 1'b1;
                  hi          <= res_hi;
                  lo          <= res_lo;
                  div_by_zero <= res_dbz;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-003 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-004 SHALL have port op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port in1  input  32  multiplicand or dividend.
REQ-006 SHALL have port in2  input  32  multiplier or divisor.
REQ-007 SHALL have port busy  output  1  high in RUN and DONE.
REQ-008 SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port hi  output  32  product[63:32] or remainder.
REQ-010 SHALL have port lo  output  32  product[31:0] or quotient.
REQ-011 SHALL have port div_by_zero  output  1  set with done when a divide had in2 == 0.

Function
REQ-012 SHALL implement states IDLE, RUN and DONE: IDLE->RUN on start; RUN->DONE after 32 iterations; DONE->IDLE unconditionally.
REQ-013 SHALL capture op, in1 and in2 on the accepting edge; later input changes SHALL NOT affect the result.
REQ-014 SHALL ignore start in RUN and DONE; no queuing.
REQ-015 SHALL use a 5-bit iteration counter, cleared on accept, performing one shift-add (multiply) or one restoring shift-subtract (divide) step per RUN cycle, for counts 0..31.
REQ-016 SHALL give a latency of 33 cycles: start sampled at edge T, done high during cycle T+33 and busy high during cycles T+1..T+33.
REQ-017 SHALL update hi, lo and div_by_zero only on the edge entering DONE, and hold them until the next entry to DONE.
REQ-018 SHALL perform signed ops (MULT, DIV) on operand magnitudes and then apply the sign: the product sign is in1[31]^in2[31], the quotient sign is in1[31]^in2[31], and the remainder sign is in1[31].
REQ-019 SHALL return the full 64-bit two's-complement product for MULT and MULTU: {hi,lo}.
REQ-020 SHALL truncate the DIV and DIVU quotient toward zero, with in1 == lo*in2 + hi.
REQ-021 SHALL give lo=0x80000000 and hi=0 for DIV 0x80000000 / 0xFFFFFFFF, with no error flag.
REQ-022 SHALL, for a divide with in2 == 0, keep the normal 33-cycle latency and give lo=0xFFFFFFFF, hi=in1 and div_by_zero=1.
REQ-023 SHALL hold div_by_zero at 0 for multiplies and for divides with in2 != 0.

Reset
REQ-024 SHALL, while rst_n=0, force state to IDLE, the counter to 0, busy=0, done=0, hi=0, lo=0 and div_by_zero=0, independent of clk.
REQ-025 SHALL abandon an in-flight operation when rst_n is asserted during RUN or DONE, producing no done pulse.
REQ-026 SHALL make the first start sampled at a clk edge after rst_n deasserts begin a normal operation.

Configuration
REQ-027 SHALL include the divide datapath when MULDIV_DIV_EN is defined, with behaviour as above.
REQ-028 SHALL, when MULDIV_DIV_EN is undefined, omit the divider: an op of 10 or 11 SHALL go IDLE->DONE directly with done at T+1, hi=0, lo=0 and div_by_zero=0; MULT and MULTU are unchanged.

Verification
REQ-029 SHALL cover MULTU in1=0xFFFFFFFF, in2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 cycles after start.
REQ-030 SHALL cover MULT in1=0xFFFFFFFD (-3), in2=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-031 SHALL cover DIV in1=0xFFFFFFF9 (-7), in2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 SHALL cover DIVU in1=100, in2=0 -> lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1 with done.
REQ-033 SHALL cover start reasserted with different operands during RUN -> ignored, with the original result delivered; start in the cycle after done -> accepted.
REQ-034 SHALL cover rst_n pulsed low at RUN iteration 10 -> busy=0 and hi=lo=0 immediately, with no done pulse; then rerun MULTU 6*7 -> lo=42, hi=0.
